alu_mdu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational register-to-register ALU. Executes RV base ops (funct3 + sub/sra bit) in one registered cycle, and RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) iteratively. Sits in the execute stage; the pipeline stalls on o_ready/o_valid.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/mdu_iter.sv | 90 +++++++++
 rtl/alu_mdu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_mdu_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU/MDU: funct3 encodings, FSM states, default width.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  // Base integer table (i_mext = 0)
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // M-extension table (i_mext = 1)
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath on operand magnitudes: one shift-add or
// restore step per cycle, first step taken on the start cycle, signs fixed on output.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              div_i,
  input  logic              a_signed_i,
  input  logic              b_signed_i,
  input  logic [XLEN-1:0]   dataa_i,
  input  logic [XLEN-1:0]   datab_i,
  output logic              done_o,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN-1:0]   quo_o,
  output logic [XLEN-1:0]   rem_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d, acc_src;
  logic [XLEN-1:0]   opb_q, opb_d, mag_a, mag_b;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d, pneg_q, pneg_d, rneg_q, rneg_d;
  logic [XLEN:0]     sum, rem_s, diff;
  logic              active, is_div, neg_a, neg_b;

  assign neg_a  = a_signed_i & dataa_i[XLEN-1];
  assign neg_b  = b_signed_i & datab_i[XLEN-1];
  assign mag_a  = neg_a ? -dataa_i : dataa_i;
  assign mag_b  = neg_b ? -datab_i : datab_i;
  assign done_o = (cnt_q == CNT_LAST);
  // Counter parks at XLEN after the last step until the next start.
  assign active = start_i | ((cnt_q != '0) & ~done_o);

  always_comb begin
    acc_src = start_i ? {{XLEN{1'b0}}, mag_a} : acc_q;
    opb_d   = start_i ? mag_b : opb_q;
    is_div  = start_i ? div_i : div_q;
    sum     = {1'b0, acc_src[2*XLEN-1:XLEN]} + (acc_src[0] ? {1'b0, opb_d} : '0);
    rem_s   = acc_src[2*XLEN-1:XLEN-1];
    diff    = rem_s - {1'b0, opb_d};
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pneg_d  = pneg_q;
    rneg_d  = rneg_q;
    if (active) begin
      if (is_div) begin
        acc_d = diff[XLEN] ? {rem_s[XLEN-1:0], acc_src[XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0], acc_src[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {sum, acc_src[XLEN-1:1]};
      end
      cnt_d = start_i ? CNT_W'(1) : cnt_q + 1'b1;
    end
    if (start_i) begin
      div_d  = div_i;
      pneg_d = neg_a ^ neg_b;
      rneg_d = neg_a;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      pneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pneg_q <= pneg_d;
      rneg_q <= rneg_d;
    end
  end

  assign prod_o = pneg_q ? -acc_q : acc_q;
  assign quo_o  = pneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_o  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

endmodule

// File: rtl/alu_mdu_seq.sv
// Handshaked execute-stage ALU: single-cycle base ops inline, iterative M ops via mdu_iter.
// Optional o_overflow output for ADD/SUB when ALU_OVERFLOW_EN is defined.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic            i_sub_sra,
  input  logic            i_mext,
  input  logic [XLEN-1:0] i_dataa,
  input  logic [XLEN-1:0] i_datab,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_datac,
`ifdef ALU_OVERFLOW_EN
  output logic            o_overflow,
`endif
  output logic            o_busy
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   datac_q, datac_d, alu_res, spec_res, mdu_res, addsub, quo, rem;
  logic [2*XLEN-1:0] prod;
  logic [SH_W-1:0]   shamt;
  logic              accept, mdu_start, mdu_done, is_special, a_signed, b_signed;

  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q == MUL) | (state_q == DIV);
  // DONE being drained this cycle counts as idle so base ops can stream one per cycle.
  assign o_ready = (state_q == IDLE) | (o_valid & i_ready);
  assign accept  = i_valid & o_ready;
  assign o_datac = datac_q;
  assign shamt   = i_datab[SH_W-1:0];
  assign addsub  = i_sub_sra ? (i_dataa - i_datab) : (i_dataa + i_datab);

  always_comb begin
    case (i_funct3)
      F3_ADD:  alu_res = addsub;
      F3_SLL:  alu_res = i_dataa << shamt;
      F3_SLT:  alu_res = XLEN'($signed(i_dataa) < $signed(i_datab));
      F3_SLTU: alu_res = XLEN'(i_dataa < i_datab);
      F3_XOR:  alu_res = i_dataa ^ i_datab;
      F3_SR:   alu_res = i_sub_sra ? $unsigned($signed(i_dataa) >>> shamt) : (i_dataa >> shamt);
      F3_OR:   alu_res = i_dataa | i_datab;
      default: alu_res = i_dataa & i_datab;
    endcase
  end

  always_comb begin
    case (i_funct3)
      F3_MULHSU:                   begin a_signed = 1'b1; b_signed = 1'b0; end
      F3_MULHU, F3_DIVU, F3_REMU:  begin a_signed = 1'b0; b_signed = 1'b0; end
      default:                     begin a_signed = 1'b1; b_signed = 1'b1; end
    endcase
  end

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign is_special = i_funct3[2] & ((i_datab == '0) |
                      (~i_funct3[0] & (i_dataa == MIN_NEG) & (i_datab == '1)));
  assign spec_res   = (i_datab == '0) ? (i_funct3[1] ? i_dataa : '1)
                                      : (i_funct3[1] ? '0 : i_dataa);
  assign mdu_res    = (state_q == MUL) ? ((f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                                       : ((f3_q == F3_REM || f3_q == F3_REMU) ? rem : quo);

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .start_i    (mdu_start),
    .div_i      (i_funct3[2]),
    .a_signed_i (a_signed),
    .b_signed_i (b_signed),
    .dataa_i    (i_dataa),
    .datab_i    (i_datab),
    .done_o     (mdu_done),
    .prod_o     (prod),
    .quo_o      (quo),
    .rem_o      (rem)
  );

`ifdef ALU_OVERFLOW_EN
  logic ovf_q, ovf_d, alu_ovf;
  assign alu_ovf = (i_funct3 == F3_ADD) & (addsub[XLEN-1] ^ i_dataa[XLEN-1]) &
                   (i_sub_sra ? (i_dataa[XLEN-1] ^ i_datab[XLEN-1])
                              : ~(i_dataa[XLEN-1] ^ i_datab[XLEN-1]));
  assign o_overflow = ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (accept) ovf_d = ~i_mext & alu_ovf;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    datac_d   = datac_q;
    f3_d      = f3_q;
    mdu_start = 1'b0;
    case (state_q)
      MUL, DIV: if (mdu_done) begin
        state_d = DONE;
        datac_d = mdu_res;
      end
      DONE:     if (i_ready) state_d = IDLE;
      default:  ;
    endcase
    if (accept) begin
      f3_d = i_funct3;
      if (!i_mext) begin
        state_d = DONE;
        datac_d = alu_res;
      end else if (!i_funct3[2]) begin
        state_d   = MUL;
        mdu_start = 1'b1;
      end else if (is_special) begin
        state_d = DONE;
        datac_d = spec_res;
      end else begin
        state_d   = DIV;
        mdu_start = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      datac_q <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      datac_q <= datac_d;
      f3_q    <= f3_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq (XLEN=32); o_overflow checked when ALU_OVERFLOW_EN is defined.
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_funct3 = 3'b000;
  logic        i_sub_sra = 1'b0;
  logic        i_mext = 1'b0;
  logic [31:0] i_dataa = '0;
  logic [31:0] i_datab = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_datac;
  logic        o_busy;
`ifdef ALU_OVERFLOW_EN
  logic        o_overflow;
`endif

  int total = 0;
  int bad   = 0;

  alu_mdu_seq #(.XLEN(32)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_funct3  (i_funct3),
    .i_sub_sra (i_sub_sra),
    .i_mext    (i_mext),
    .i_dataa   (i_dataa),
    .i_datab   (i_datab),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_datac   (o_datac),
`ifdef ALU_OVERFLOW_EN
    .o_overflow(o_overflow),
`endif
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op with i_ready low, wait (bounded) for o_valid, check, then drain.
  task automatic run_op(input string tag, input logic mext, input logic [2:0] f3,
                        input logic ss, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input logic exp_ovf);
    int lat;
    i_mext = mext; i_funct3 = f3; i_sub_sra = ss; i_dataa = a; i_datab = b;
    i_valid = 1'b1; i_ready = 1'b0;
    chk({tag, "_ready"}, o_ready, 1'b1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    if (exp_lat > 1) chk({tag, "_busy"}, o_busy, 1'b1);
    while (!o_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_valid"}, o_valid, 1'b1);
    chk({tag, "_data"}, o_datac, exp);
    chk({tag, "_lat"}, lat, exp_lat);
`ifdef ALU_OVERFLOW_EN
    chk({tag, "_ovf"}, o_overflow, exp_ovf);
`else
    if (exp_ovf !== 1'b0 && exp_ovf !== 1'b1) $display("note: %s overflow arg undefined", tag);
`endif
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] b2b_a [4];
    logic [31:0] b2b_b [4];
    logic [31:0] b2b_e [4];
    b2b_a = '{32'd1, 32'd2, 32'd3, 32'hFFFFFFFF};
    b2b_b = '{32'd1, 32'd2, 32'd3, 32'd2};
    b2b_e = '{32'd2, 32'd4, 32'd6, 32'd1};

    #12;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_data", o_datac, 32'h0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    @(negedge clk); i_rst = 1'b0;
    @(posedge clk); #1;

    // Base ops
    run_op("add_ovf", 1'b0, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 1'b1);
    run_op("sub",     1'b0, 3'b000, 1'b1, 32'd5,        32'd7,        32'hFFFFFFFE, 1, 1'b0);
    run_op("sub_ovf", 1'b0, 3'b000, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1'b1);
    run_op("sra",     1'b0, 3'b101, 1'b1, 32'h80000000, 32'd4,        32'hF8000000, 1, 1'b0);
    run_op("srl",     1'b0, 3'b101, 1'b0, 32'h80000000, 32'd4,        32'h08000000, 1, 1'b0);
    run_op("sll",     1'b0, 3'b001, 1'b0, 32'h00000001, 32'h0000003F, 32'h80000000, 1, 1'b0);
    run_op("slt",     1'b0, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1, 1'b0);
    run_op("sltu",    1'b0, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 1'b0);
    run_op("or",      1'b0, 3'b110, 1'b0, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0, 1, 1'b0);
    run_op("and",     1'b0, 3'b111, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1, 1'b0);

    // Multiply
    run_op("mulh",    1'b1, 3'b001, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
    run_op("mulhsu",  1'b1, 3'b010, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
    run_op("mul",     1'b1, 3'b000, 1'b0, 32'd3,        32'hFFFFFFFC, 32'hFFFFFFF4, 33, 1'b0);
    run_op("mulhu",   1'b1, 3'b011, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);

    // Divide and special cases
    run_op("div",     1'b1, 3'b100, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
    run_op("rem",     1'b1, 3'b110, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
    run_op("divu_z",  1'b1, 3'b101, 1'b0, 32'd1234,     32'd0,        32'hFFFFFFFF, 1,  1'b0);
    run_op("remu_z",  1'b1, 3'b111, 1'b0, 32'd1234,     32'd0,        32'd1234,     1,  1'b0);
    run_op("div_ov",  1'b1, 3'b100, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
    run_op("rem_ov",  1'b1, 3'b110, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1'b0);

    // Backpressure: result must hold while i_ready stays low
    i_mext = 1'b0; i_funct3 = 3'b100; i_sub_sra = 1'b0;
    i_dataa = 32'hF0F0F0F0; i_datab = 32'hFF00FF00;
    i_valid = 1'b1; i_ready = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", o_valid, 1'b1);
      chk("bp_data", o_datac, 32'h0FF00FF0);
      chk("bp_ready", o_ready, 1'b0);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drain", o_valid, 1'b0);

    // Back-to-back ADDs, one result per cycle
    for (int k = 0; k < 4; k++) begin
      i_mext = 1'b0; i_funct3 = 3'b000; i_sub_sra = 1'b0;
      i_dataa = b2b_a[k]; i_datab = b2b_b[k]; i_valid = 1'b1;
      chk("b2b_ready", o_ready, 1'b1);
      @(posedge clk); #1;
      chk("b2b_valid", o_valid, 1'b1);
      chk("b2b_data", o_datac, b2b_e[k]);
    end
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end", o_valid, 1'b0);
    i_ready = 1'b0;

    // Reset in the middle of a divide
    i_mext = 1'b1; i_funct3 = 3'b100; i_dataa = 32'd1000; i_datab = 32'd3;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", o_busy, 1'b1);
    chk("mid_valid", o_valid, 1'b0);
    i_rst = 1'b1;
    #1;
    chk("rst2_busy", o_busy, 1'b0);
    chk("rst2_valid", o_valid, 1'b0);
    chk("rst2_ready", o_ready, 1'b1);
    chk("rst2_data", o_datac, 32'h0);
    @(negedge clk); i_rst = 1'b0;
    @(posedge clk); #1;
    run_op("divu",    1'b1, 3'b101, 1'b0, 32'd100,      32'd7,        32'd14,       33, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
